// File: rtl/washer_pkg.sv
// Shared definitions for the parametrised washer controller.
// Holds the state encoding (also driven out on the phase port), the bit
// order of the actuator vector {Agitator,Motor,Pump,Speed,Water}, and small
// decode helpers used by the controller.
package washer_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FILL_W  = 4'd1,
        S_WASH    = 4'd2,
        S_DRAIN_W = 4'd3,
        S_FILL_R  = 4'd4,
        S_RINSE   = 4'd5,
        S_DRAIN_R = 4'd6,
        S_SPIN    = 4'd7,
        S_DONE    = 4'd8
    } state_e;

    // Actuator vector bit positions, MSB first: {Agitator,Motor,Pump,Speed,Water}
    localparam int ACT_W        = 5;
    localparam int ACT_AGITATOR = 4;
    localparam int ACT_MOTOR    = 3;
    localparam int ACT_PUMP     = 2;
    localparam int ACT_SPEED    = 1;
    localparam int ACT_WATER    = 0;

    // Timed states are every state that runs the phase timer.
    function automatic logic is_timed(input state_e s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

    // Actuator pattern for a state, before any door hold is applied.
    function automatic logic [ACT_W-1:0] act_decode(input state_e s);
        logic [ACT_W-1:0] a;
        a = '0;
        case (s)
            S_FILL_W, S_FILL_R: a[ACT_WATER] = 1'b1;
            S_WASH, S_RINSE: begin
                a[ACT_AGITATOR] = 1'b1;
                a[ACT_MOTOR]    = 1'b1;
            end
            S_DRAIN_W, S_DRAIN_R: a[ACT_PUMP] = 1'b1;
            S_SPIN: begin
                a[ACT_MOTOR] = 1'b1;
                a[ACT_PUMP]  = 1'b1;
                a[ACT_SPEED] = 1'b1;
            end
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/washer_timer_param.sv
// Scaled phase timer for the washer controller.
// A prescaler divides clk by TICK_DIV into time units; a unit counter counts
// units within the current phase.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   clr    : clear prescaler and unit counter (state entry)
//   hold   : freeze both counters (door open)
//   dur    : phase duration in units
//   expire : high on the last clk cycle of the phase (never while held)
module washer_timer_param #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             hold,
    input  logic [CNT_W-1:0] dur,
    output logic             expire
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] units_q, units_d;
    logic             wrap;

    always_comb begin
        wrap    = (pre_q == PRE_LAST);
        // expire deliberately ignores clr: clr is derived from expire upstream
        expire  = !hold && wrap && (units_q == dur - CNT_W'(1));
        pre_d   = pre_q;
        units_d = units_q;
        if (clr) begin
            pre_d   = '0;
            units_d = '0;
        end else if (!hold) begin
            if (wrap) begin
                pre_d   = '0;
                units_d = units_q + CNT_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            units_q <= '0;
        end else begin
            pre_q   <= pre_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/washer_ctrl_param.sv
// Parametrised wash-machine controller: sequencer FSM, load-scaled duration
// mux, rinse counter and door pause, driving the actuator relays.
//   clk, reset            : clock, asynchronous active-low reset
//   Start, Door, load     : debounced start level, door open, load level
//   Agitator..Water       : actuator relays (registered)
//   Busy, Done, phase     : status (registered)
module washer_ctrl_param
    import washer_pkg::*;
#(
    parameter int LOAD_W   = 2,
    parameter int TICK_DIV = 50_000_000,
    parameter int FILL_T   = 4,
    parameter int WASH_T   = 10,
    parameter int RINSE_T  = 6,
    parameter int DRAIN_T  = 3,
    parameter int SPIN_T   = 8,
    parameter int RINSES   = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic              Door,
    input  logic [LOAD_W-1:0] load,
    output logic              Agitator,
    output logic              Motor,
    output logic              Pump,
    output logic              Speed,
    output logic              Water,
    output logic              Busy,
    output logic              Done,
    output logic [3:0]        phase
);

    localparam int RC_W = (RINSES > 1) ? $clog2(RINSES) : 1;

    state_e            state_q, state_d;
    logic [LOAD_W-1:0] load_q, load_d;
    logic [RC_W-1:0]   rinse_q, rinse_d;
    logic [ACT_W-1:0]  act_q, act_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  scale;
    logic [CNT_W-1:0]  dur;
    logic              hold;
    logic              clr;
    logic              expire;

    washer_timer_param #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .hold   (hold),
        .dur    (dur),
        .expire (expire)
    );

    // Duration of the current phase in units; drain and spin are not scaled.
    always_comb begin
        scale = CNT_W'(load_q) + CNT_W'(1);
        case (state_q)
            S_FILL_W, S_FILL_R:   dur = CNT_W'(FILL_T) * scale;
            S_WASH:               dur = CNT_W'(WASH_T) * scale;
            S_RINSE:              dur = CNT_W'(RINSE_T) * scale;
            S_DRAIN_W, S_DRAIN_R: dur = CNT_W'(DRAIN_T);
            S_SPIN:               dur = CNT_W'(SPIN_T);
            default:              dur = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        rinse_d = rinse_q;
        hold    = Door && is_timed(state_q);
        case (state_q)
            S_IDLE: begin
                rinse_d = '0;
                if (Start && !Door) begin
                    state_d = S_FILL_W;
                    load_d  = load;
                end
            end
            S_FILL_W:  if (expire) state_d = S_WASH;
            S_WASH:    if (expire) state_d = S_DRAIN_W;
            S_DRAIN_W: if (expire) state_d = S_FILL_R;
            S_FILL_R:  if (expire) state_d = S_RINSE;
            S_RINSE:   if (expire) state_d = S_DRAIN_R;
            S_DRAIN_R: begin
                if (expire) begin
                    if (rinse_q < RC_W'(RINSES - 1)) begin
                        rinse_d = rinse_q + RC_W'(1);
                        state_d = S_FILL_R;
                    end else begin
                        state_d = S_SPIN;
                    end
                end
            end
            S_SPIN:    if (expire) state_d = S_DONE;
            S_DONE:    if (Door) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Every state entry restarts the timer from zero.
        clr = (state_d != state_q);

        // Outputs decode the next state so they move with the state register.
        act_d  = (Door && is_timed(state_d)) ? '0 : act_decode(state_d);
        busy_d = is_timed(state_d);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            load_q  <= '0;
            rinse_q <= '0;
            act_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            rinse_q <= rinse_d;
            act_q   <= act_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Agitator = act_q[ACT_AGITATOR];
    assign Motor    = act_q[ACT_MOTOR];
    assign Pump     = act_q[ACT_PUMP];
    assign Speed    = act_q[ACT_SPEED];
    assign Water    = act_q[ACT_WATER];
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_washer_ctrl_param.sv
// Self-checking bench for washer_ctrl_param: directed scenarios plus random
// Start/Door/load traffic, compared every cycle against a schedule-based
// reference model (a queue of phases with durations in clk cycles).
module tb_washer_ctrl_param;

    localparam int LOAD_W   = 2;
    localparam int TICK_DIV = 4;
    localparam int FILL_T   = 2;
    localparam int WASH_T   = 3;
    localparam int RINSE_T  = 2;
    localparam int DRAIN_T  = 1;
    localparam int SPIN_T   = 2;
    localparam int RINSES   = 2;
    localparam int CNT_W    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              Start;
    logic              Door;
    logic [LOAD_W-1:0] load;
    logic              Agitator, Motor, Pump, Speed, Water, Busy, Done;
    logic [3:0]        phase;
    logic [10:0]       dut_vec;

    always #5 clk = ~clk;

    washer_ctrl_param #(
        .LOAD_W(LOAD_W), .TICK_DIV(TICK_DIV), .FILL_T(FILL_T), .WASH_T(WASH_T),
        .RINSE_T(RINSE_T), .DRAIN_T(DRAIN_T), .SPIN_T(SPIN_T), .RINSES(RINSES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(rst_n), .Start(Start), .Door(Door), .load(load),
        .Agitator(Agitator), .Motor(Motor), .Pump(Pump), .Speed(Speed),
        .Water(Water), .Busy(Busy), .Done(Done), .phase(phase)
    );

    assign dut_vec = {phase, Agitator, Motor, Pump, Speed, Water, Busy, Done};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          sched_ph[$];
    int          sched_dur[$];
    int          m_idx;
    int          m_el;
    logic [10:0] m_exp;

    // Expected {phase, Agitator,Motor,Pump,Speed,Water, Busy, Done}
    function automatic logic [10:0] exp_vec(input int ph, input logic door);
        logic [4:0] act;
        logic       timed;
        logic [3:0] p4;
        p4 = ph[3:0];
        case (ph)
            1, 4:    act = 5'b00001;
            2, 5:    act = 5'b11000;
            3, 6:    act = 5'b00100;
            7:       act = 5'b01110;
            default: act = 5'b00000;
        endcase
        timed = (ph >= 1) && (ph <= 7);
        if (door && timed) act = 5'b00000;
        return {p4, act, timed, (ph == 8)};
    endfunction

    task automatic build_sched(input int ld);
        sched_ph.delete();
        sched_dur.delete();
        sched_ph.push_back(1); sched_dur.push_back(FILL_T * (ld + 1) * TICK_DIV);
        sched_ph.push_back(2); sched_dur.push_back(WASH_T * (ld + 1) * TICK_DIV);
        sched_ph.push_back(3); sched_dur.push_back(DRAIN_T * TICK_DIV);
        for (int r = 0; r < RINSES; r++) begin
            sched_ph.push_back(4); sched_dur.push_back(FILL_T * (ld + 1) * TICK_DIV);
            sched_ph.push_back(5); sched_dur.push_back(RINSE_T * (ld + 1) * TICK_DIV);
            sched_ph.push_back(6); sched_dur.push_back(DRAIN_T * TICK_DIV);
        end
        sched_ph.push_back(7); sched_dur.push_back(SPIN_T * TICK_DIV);
        sched_ph.push_back(8); sched_dur.push_back(0);
    endtask

    task automatic model_reset();
        m_idx = -1;
        m_el  = 0;
        m_exp = exp_vec(0, 1'b0);
    endtask

    task automatic model_step();
        int ph;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ph = (m_idx < 0) ? 0 : sched_ph[m_idx];
        if (ph == 0) begin
            if (Start && !Door) begin
                build_sched(int'(load));
                m_idx = 0;
                m_el  = 0;
            end
        end else if (ph == 8) begin
            if (Door) m_idx = -1;
        end else if (!Door) begin
            m_el++;
            if (m_el == sched_dur[m_idx]) begin
                m_idx++;
                m_el = 0;
            end
        end
        ph = (m_idx < 0) ? 0 : sched_ph[m_idx];
        m_exp = exp_vec(ph, Door);
    endtask

    // One clock: model sees the same inputs the DUT samples, check at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("cyc", {21'd0, dut_vec}, {21'd0, m_exp});
    endtask

    task automatic start_cycle(input logic [LOAD_W-1:0] ld);
        load  = ld;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic count_phase(input int code, input int bound, output int n);
        n = 0;
        while (int'(phase) == code && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic run_until_done(input int bound, input bit start_in_rinse, output int n);
        n = 0;
        while (!Done && n < bound) begin
            Start = start_in_rinse && (phase == 4'd5);
            tick();
            n++;
        end
        Start = 1'b0;
        check_eq("done_reached", {31'd0, Done}, 32'd1);
    endtask

    task automatic leave_done();
        Door = 1'b1;
        tick();
        Door = 1'b0;
        tick();
    endtask

    int n;
    int cycles_done;

    initial begin
        rst_n = 1'b0;
        Start = 1'b0;
        Door  = 1'b0;
        load  = '0;
        model_reset();
        repeat (3) tick();
        check_eq("reset_state", {21'd0, dut_vec}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Full cycle at load 0, Start held during RINSE must be ignored.
        start_cycle(2'd0);
        run_until_done(500, 1'b1, n);
        check_eq("full_len", n, 72);
        $display("txn full cycle load=0 len=%0d", n);
        Start = 1'b1;
        repeat (2) tick();
        Start = 1'b0;
        check_eq("done_ignores_start", {28'd0, phase}, 32'd8);
        Door = 1'b1;
        tick();
        check_eq("done_exit_phase", {28'd0, phase}, 32'd0);
        check_eq("done_exit_flag", {31'd0, Done}, 32'd0);
        Door = 1'b0;
        tick();
        $display("txn done->idle on door open");

        // Load scaling; load change mid-WASH ignored.
        start_cycle(2'd3);
        count_phase(1, 200, n);
        check_eq("load3_fill", n, 32);
        repeat (5) tick();
        load = 2'd0;
        count_phase(2, 200, n);
        check_eq("load3_wash", n + 5, 48);
        count_phase(3, 200, n);
        check_eq("load3_drain", n, 4);
        run_until_done(1000, 1'b0, n);
        $display("txn load=3 cycle complete");
        leave_done();

        // Door pause at WASH clk 5 for 10 clk.
        start_cycle(2'd0);
        count_phase(1, 200, n);
        check_eq("pause_fill", n, 8);
        repeat (5) tick();
        Door = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("pause_act", {27'd0, Agitator, Motor, Pump, Speed, Water}, 32'd0);
            check_eq("pause_phase", {28'd0, phase}, 32'd2);
            check_eq("pause_busy", {31'd0, Busy}, 32'd1);
        end
        Door = 1'b0;
        count_phase(2, 200, n);
        check_eq("pause_wash_len", n + 15, 22);
        run_until_done(500, 1'b0, n);
        $display("txn door pause cycle complete");
        leave_done();

        // Start with door open is ignored.
        Door  = 1'b1;
        Start = 1'b1;
        repeat (3) tick();
        check_eq("start_door_open", {28'd0, phase}, 32'd0);
        Start = 1'b0;
        Door  = 1'b0;
        tick();
        $display("txn start gated by open door");

        // Asynchronous reset mid-SPIN, then a fresh full cycle.
        start_cycle(2'd0);
        n = 0;
        while (phase != 4'd7 && n < 200) begin
            tick();
            n++;
        end
        check_eq("reach_spin", {28'd0, phase}, 32'd7);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", {21'd0, dut_vec}, 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_idle", {28'd0, phase}, 32'd0);
        start_cycle(2'd0);
        run_until_done(500, 1'b0, n);
        check_eq("post_rst_len", n, 72);
        $display("txn reset mid-spin, rerun len=%0d", n);
        leave_done();

        // Random traffic.
        cycles_done = 0;
        for (int i = 0; i < 4000; i++) begin
            Start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) Door = ~Door;
            load = LOAD_W'($urandom_range(0, 3));
            tick();
            if (Done && m_el == 0 && phase == 4'd8 && Door == 1'b0) cycles_done++;
        end
        Start = 1'b0;
        Door  = 1'b0;
        $display("txn random traffic: 4000 clk, %0d clk observed in DONE", cycles_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
